hazard_unit_mc: RTL
===================

# hazard_unit_mc

Second-generation pipeline hazard controller for the 5-stage RISC-V core. It keeps the existing forwarding, load-use stall and branch flush behaviour. It adds a sequential multi-cycle execute tracker for mul/div with parametrised latency, a data-memory wait handshake that freezes the pipe through Memory, and optional saturating stall/flush performance counters. It sits beside the datapath and drives every pipeline-register enable and clear.

## Interface
- REG_AW, 5: register-address width.
- MD_LAT, 4: total cycles a mul/div occupies Execute; legal range ≥ 2.
- CNT_W, 16: performance-counter width.

- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears FSM, down-counter and perf counters.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  stage register addresses.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- ResultSrcEb0  in  1  instruction in Execute is a load.
- RegWriteM, RegWriteW  in  1  writeback enables.
- MdStartE  in  1  mul/div op present in Execute.
- MemReqM  in  1  Memory-stage access active.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold pipeline register.
- FlushD, FlushE, FlushM, FlushW  out  1  clear pipeline register (insert bubble).
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M.
- MdBusy  out  1  FSM not in RUN.
- MdDoneE  out  1  mul/div result valid and leaving Execute this cycle.
- LuStallCnt, MdStallCnt, MemStallCnt, FlushCnt  out  CNT_W  perf counters.

## Operation
- Forwarding is combinational. For each source Rs≠0: match with RdM & RegWriteM gives 10; otherwise a match with RdW & RegWriteW gives 01; otherwise 00. M has priority over W. Forwarding is independent of stalls.
- memStall = MemReqM & ~MemReadyM.
- lwStall = ResultSrcEb0 & RdE≠0 & (Rs1D==RdE | Rs2D==RdE).
- mdStall = (state==RUN & MdStartE) | (state==BUSY & cnt≠0) | (state==HOLD & memStall).
- Priority, highest first: memory wait, mul/div, load-use, branch.
  - StallM = FlushW = memStall.
  - StallE = memStall | mdStall.
  - FlushM = mdStall & ~memStall.
  - StallF = StallD = StallE | lwStall.
  - FlushE = ~StallE & (lwStall | PCSrcE).
  - FlushD = ~StallE & PCSrcE.
- FSM states are RUN, BUSY and HOLD:
  - RUN: if MdStartE, load cnt = MD_LAT-2 and go to BUSY.
  - BUSY: if cnt≠0, decrement. If cnt==0 and ~memStall, assert MdDoneE and go to RUN. If cnt==0 and memStall, go to HOLD.
  - HOLD: wait; when ~memStall, assert MdDoneE and go to RUN.
- The down-counter is $clog2(MD_LAT) bits wide and keeps running during a memory stall. Completion is only deferred through HOLD.
- A branch that coincides with a stall is deferred: PCSrcE stays held in E, and the flush fires in the release cycle.

## Timing
- Reset values: all Stall/Flush 0, Forward 00, MdBusy 0, MdDoneE 0, counters 0, state RUN. These hold whenever inputs are idle.
- Reset asserted mid-operation aborts a mul/div immediately. After reset, outputs follow the inputs combinationally.
- Mul/div with no memory wait:
  - Cycles 0..MD_LAT-2: StallE and FlushM high.
  - Cycle MD_LAT-1: MdDoneE high, no stall.
- Load-use costs exactly one bubble cycle. A taken branch costs two flushed slots.
- All outputs are combinational from inputs and registered state; no output is registered. MdBusy is registered-state decode.

## Configuration
- HAZARD_PERF_EN defined: four saturating CNT_W counters each increment by 1 per cycle:
  - LuStallCnt: lwStall & ~StallE.
  - MdStallCnt: mdStall.
  - MemStallCnt: memStall.
  - FlushCnt: FlushD | FlushE.
  - Counters hold at all-ones.
- HAZARD_PERF_EN undefined: the ports remain and are tied to 0; no counter flops exist.

## Test plan
- Forwarding: RdM=RdW=Rs1E=5, both writes on, gives ForwardAE=10. With Rs1E=0, ForwardAE=00. With RegWriteM=0, ForwardAE=01.
- Load-use: load to x7 in E, Rs2D=7, gives StallF=StallD=FlushE=1 for one cycle. With RdE=0, no stall.
- Mul/div, MD_LAT=4, MdStartE held: StallE=FlushM=1 for 3 cycles, then MdDoneE=1 in cycle 4 and MdBusy drops.
- Mul/div overlapping memory wait: MemReadyM low from cycle 2 to cycle 6. FSM enters HOLD, and MdDoneE=1 only in the first ready cycle. FlushM=0 while StallM=1.
- Branch during memory wait: PCSrcE=1 held with memStall gives FlushD=FlushE=0. In the cycle ready rises, FlushD=FlushE=1.
- Reset asserted in BUSY gives state RUN and all outputs 0 asynchronously. With HAZARD_PERF_EN, counters reset and saturate at 2^CNT_W-1 (check with CNT_W=3).

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use, branch flush,
// multi-cycle mul/div tracking and memory-wait freeze. Optional perf counters under `HAZARD_PERF_EN`.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              PCSrcE,
    input  logic              ResultSrcEb0,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MdStartE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdBusy,
    output logic              MdDoneE,
    output logic [CNT_W-1:0]  LuStallCnt,
    output logic [CNT_W-1:0]  MdStallCnt,
    output logic [CNT_W-1:0]  MemStallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam int MDC_W = $clog2(MD_LAT);
    localparam logic [MDC_W-1:0] MDC_LOAD = MDC_W'(MD_LAT - 2);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MDC_W-1:0] r_cnt;
    logic [MDC_W-1:0] w_cnt_nxt;
    logic             w_mem_stall;
    logic             w_lw_stall;
    logic             w_md_stall;
    logic             w_md_done;

    // M-stage result wins over W-stage when both write the same register.
    assign ForwardAE = ((Rs1E != '0) && (Rs1E == RdM) && RegWriteM) ? 2'b10 :
                       ((Rs1E != '0) && (Rs1E == RdW) && RegWriteW) ? 2'b01 : 2'b00;
    assign ForwardBE = ((Rs2E != '0) && (Rs2E == RdM) && RegWriteM) ? 2'b10 :
                       ((Rs2E != '0) && (Rs2E == RdW) && RegWriteW) ? 2'b01 : 2'b00;

    assign w_mem_stall = MemReqM & ~MemReadyM;
    assign w_lw_stall  = ResultSrcEb0 & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The down-counter runs through a memory wait; only completion is deferred via HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_stall  = 1'b0;
        w_md_done   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (MdStartE) begin
                    w_md_stall  = 1'b1;
                    w_cnt_nxt   = MDC_LOAD;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_md_stall = 1'b1;
                    w_cnt_nxt  = r_cnt - 1'b1;
                end else if (!w_mem_stall) begin
                    w_md_done   = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_mem_stall) begin
                    w_md_stall = 1'b1;
                end else begin
                    w_md_done   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign MdBusy  = (r_state != S_RUN);
    assign MdDoneE = w_md_done;

    assign StallM = w_mem_stall;
    assign FlushW = w_mem_stall;
    assign StallE = w_mem_stall | w_md_stall;
    assign FlushM = w_md_stall & ~w_mem_stall;
    assign StallF = StallE | w_lw_stall;
    assign StallD = StallE | w_lw_stall;
    // A branch held behind a stall flushes in the release cycle.
    assign FlushE = ~StallE & (w_lw_stall | PCSrcE);
    assign FlushD = ~StallE & PCSrcE;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_fl_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lu_cnt  <= '0;
            r_md_cnt  <= '0;
            r_mem_cnt <= '0;
            r_fl_cnt  <= '0;
        end else begin
            r_lu_cnt  <= sat_inc(r_lu_cnt, w_lw_stall & ~StallE);
            r_md_cnt  <= sat_inc(r_md_cnt, w_md_stall);
            r_mem_cnt <= sat_inc(r_mem_cnt, w_mem_stall);
            r_fl_cnt  <= sat_inc(r_fl_cnt, FlushD | FlushE);
        end
    end

    assign LuStallCnt  = r_lu_cnt;
    assign MdStallCnt  = r_md_cnt;
    assign MemStallCnt = r_mem_cnt;
    assign FlushCnt    = r_fl_cnt;
`else
    assign LuStallCnt  = '0;
    assign MdStallCnt  = '0;
    assign MemStallCnt = '0;
    assign FlushCnt    = '0;
`endif

endmodule
